// File: rtl/vga_read_request_gen.sv
// ---------------------------------------------------------------------------
// vga_read_request_gen
// Display-side timing generator for the RAW-to-RGB line-buffer read port.
// Produces active-low HS/VS, BLANK_N over the visible area, and a
// READ_Request window of WIN_W x WIN_H pixels placed at (WIN_X0, WIN_Y0).
// All outputs are registered: each pin reflects the counters one cycle back.
//
// Optional feature macro: READ_REQ_PRELOAD_EN
//   Defined   - READ_Request leads the pixel position by one cycle
//               (h range [WIN_X0-1, WIN_X0+WIN_W-1)) to cover read latency.
//   Undefined - READ_Request is aligned with BLANK_N / pixel position.
//
// Ports
//   VGA_CLK       in   pixel clock, the only clock
//   RST           in   synchronous active-high reset
//   EN            in   run request, acted on only at a frame boundary
//   VGA_HS        out  horizontal sync, active low
//   VGA_VS        out  vertical sync, active low
//   VGA_BLANK_N   out  high inside the visible area
//   READ_Request  out  high inside the read window
//   oFrameStart   out  one-cycle pulse for the first pixel of a frame
//   oBusy         out  high while the generator is running
// ---------------------------------------------------------------------------
module vga_read_request_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned WIN_X0   = 220,
   parameter int unsigned WIN_Y0   = 165,
   parameter int unsigned WIN_W    = 200,
   parameter int unsigned WIN_H    = 150
) (
   input  logic VGA_CLK,
   input  logic RST,
   input  logic EN,
   output logic VGA_HS,
   output logic VGA_VS,
   output logic VGA_BLANK_N,
   output logic READ_Request,
   output logic oFrameStart,
   output logic oBusy
);

   localparam int unsigned CNT_W   = 11;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

`ifdef READ_REQ_PRELOAD_EN
   localparam int unsigned RD_X0 = WIN_X0 - 1;
`else
   localparam int unsigned RD_X0 = WIN_X0;
`endif

   // Decode boundaries, pre-sized to the counter width
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEGIN   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEGIN   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] RD_H_BEGIN = CNT_W'(RD_X0);
   localparam logic [CNT_W-1:0] RD_H_END   = CNT_W'(RD_X0 + WIN_W);
   localparam logic [CNT_W-1:0] RD_V_BEGIN = CNT_W'(WIN_Y0);
   localparam logic [CNT_W-1:0] RD_V_END   = CNT_W'(WIN_Y0 + WIN_H);

   // Parameter sanity checks at elaboration
   if (WIN_X0 + WIN_W > H_ACTIVE) begin : g_err_win_x
      $error("vga_read_request_gen: WIN_X0+WIN_W exceeds H_ACTIVE");
   end
   if (WIN_Y0 + WIN_H > V_ACTIVE) begin : g_err_win_y
      $error("vga_read_request_gen: WIN_Y0+WIN_H exceeds V_ACTIVE");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_err_cnt
      $error("vga_read_request_gen: timing totals exceed counter range");
   end
`ifdef READ_REQ_PRELOAD_EN
   if (WIN_X0 < 1) begin : g_err_preload
      $error("vga_read_request_gen: preload needs WIN_X0 >= 1");
   end
`endif

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hCnt;
   logic [CNT_W-1:0] vCnt;

   logic hsLow;
   logic vsLow;
   logic visible;
   logic inWindow;
   logic frameOrigin;
   logic lineEnd;
   logic frameEnd;

   // Position decode from the current counters
   always_comb begin
      hsLow       = (hCnt >= HS_BEGIN) && (hCnt < HS_END);
      vsLow       = (vCnt >= VS_BEGIN) && (vCnt < VS_END);
      visible     = (hCnt < H_ACT_END) && (vCnt < V_ACT_END);
      inWindow    = (hCnt >= RD_H_BEGIN) && (hCnt < RD_H_END) &&
                    (vCnt >= RD_V_BEGIN) && (vCnt < RD_V_END);
      frameOrigin = (hCnt == '0) && (vCnt == '0);
      lineEnd     = (hCnt == H_LAST);
      frameEnd    = lineEnd && (vCnt == V_LAST);
   end

   // Control FSM, raster counters and registered pin drivers
   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         state        <= IDLE;
         hCnt         <= '0;
         vCnt         <= '0;
         VGA_HS       <= 1'b1;
         VGA_VS       <= 1'b1;
         VGA_BLANK_N  <= 1'b0;
         READ_Request <= 1'b0;
         oFrameStart  <= 1'b0;
         oBusy        <= 1'b0;
      end else begin
         // Pins follow the decode only while running; IDLE drives rest values
         if (state == RUN) begin
            VGA_HS       <= ~hsLow;
            VGA_VS       <= ~vsLow;
            VGA_BLANK_N  <= visible;
            READ_Request <= inWindow;
            oFrameStart  <= frameOrigin;
            oBusy        <= 1'b1;
         end else begin
            VGA_HS       <= 1'b1;
            VGA_VS       <= 1'b1;
            VGA_BLANK_N  <= 1'b0;
            READ_Request <= 1'b0;
            oFrameStart  <= 1'b0;
            oBusy        <= 1'b0;
         end

         case (state)
            IDLE: begin
               hCnt <= '0;
               vCnt <= '0;
               if (EN) state <= RUN;
            end
            RUN: begin
               if (lineEnd) begin
                  hCnt <= '0;
                  if (frameEnd) begin
                     vCnt <= '0;
                     // EN only matters here, so frames always complete
                     if (!EN) state <= IDLE;
                  end else begin
                     vCnt <= vCnt + CNT_W'(1);
                  end
               end else begin
                  hCnt <= hCnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               hCnt  <= '0;
               vCnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_read_request_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_read_request_gen
// Directed bench: a small-raster instance (24 x 15, window 6 x 4 at (4,3))
// for frame-level behaviour, and a default-parameter instance for the
// 640x480 horizontal timing. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_vga_read_request_gen;

`ifdef READ_REQ_PRELOAD_EN
   localparam int PRE = 1;
`else
   localparam int PRE = 0;
`endif

   logic VGA_CLK = 1'b0;
   logic RST;
   logic EN;

   logic sHs, sVs, sBlankN, sRr, sFs, sBusy;
   logic dHs, dVs, dBlankN, dRr, dFs, dBusy;

   int total = 0;
   int bad   = 0;

   always #5 VGA_CLK = ~VGA_CLK;

   // Small raster: H 16/2/3/3 (24), V 10/1/2/2 (15), window (4,3) 6x4
   vga_read_request_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .WIN_X0(4), .WIN_Y0(3), .WIN_W(6), .WIN_H(4)
   ) dutS (
      .VGA_CLK(VGA_CLK), .RST(RST), .EN(EN),
      .VGA_HS(sHs), .VGA_VS(sVs), .VGA_BLANK_N(sBlankN),
      .READ_Request(sRr), .oFrameStart(sFs), .oBusy(sBusy)
   );

   vga_read_request_gen dutD (
      .VGA_CLK(VGA_CLK), .RST(RST), .EN(EN),
      .VGA_HS(dHs), .VGA_VS(dVs), .VGA_BLANK_N(dBlankN),
      .READ_Request(dRr), .oFrameStart(dFs), .oBusy(dBusy)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge VGA_CLK);
      #1;
   endtask

   initial begin
      int vsLowCnt, hsLowCnt, blankCnt, rrCnt, rrRises, fsCnt, runLen;
      int found, busyCnt;
      logic prevRr;

      RST = 1'b1;
      EN  = 1'b0;
      tick();
      tick();
      check("rst_hs", sHs, 1);
      check("rst_vs", sVs, 1);
      check("rst_blank", sBlankN, 0);
      check("rst_rr", sRr, 0);
      check("rst_fs", sFs, 0);
      check("rst_busy", sBusy, 0);

      RST = 1'b0;
      tick();
      check("idle_busy", sBusy, 0);

      // Edge E0 samples EN: cycle 0 of RUN, pins still show IDLE
      EN = 1'b1;
      tick();
      check("entry_busy", sBusy, 0);
      check("entry_fs", sFs, 0);

      vsLowCnt = 0; hsLowCnt = 0; blankCnt = 0; rrCnt = 0;
      rrRises = 0; fsCnt = 0; runLen = 0; prevRr = 1'b0;

      // Phase A: after k ticks the pins show counter cycle k-1
      for (int k = 1; k <= 1500; k++) begin
         tick();
         if (k <= 360) begin
            if (!sVs) vsLowCnt++;
            if (!sHs) hsLowCnt++;
            if (sBlankN) blankCnt++;
            if (sFs) fsCnt++;
            if (sRr) begin
               rrCnt++;
               runLen++;
               if (!prevRr) rrRises++;
            end else if (prevRr) begin
               check("rr_width", runLen, 6);
               runLen = 0;
            end
            prevRr = sRr;
         end
         case (k)
            1: begin
               check("k1_fs", sFs, 1);
               check("k1_busy", sBusy, 1);
               check("k1_blank", sBlankN, 1);
               check("d_k1_fs", dFs, 1);
            end
            2:   check("k2_fs", sFs, 0);
            16:  check("blank_last_px", sBlankN, 1);
            17:  check("blank_fp", sBlankN, 0);
            18:  check("hs_before", sHs, 1);
            19:  check("hs_fall", sHs, 0);
            21:  check("hs_last", sHs, 0);
            22:  check("hs_rise", sHs, 1);
            76 - PRE: check("rr_pre_rise", sRr, 0);
            77 - PRE: check("rr_rise", sRr, 1);
            82 - PRE: check("rr_last", sRr, 1);
            83 - PRE: check("rr_fall", sRr, 0);
            264: check("vs_before", sVs, 1);
            265: check("vs_fall", sVs, 0);
            312: check("vs_last", sVs, 0);
            313: check("vs_rise", sVs, 1);
            360: begin
               check("frame_vs_low", vsLowCnt, 48);
               check("frame_hs_low", hsLowCnt, 45);
               check("frame_blank", blankCnt, 160);
               check("frame_rr_cnt", rrCnt, 24);
               check("frame_rr_pulses", rrRises, 4);
               check("frame_fs_cnt", fsCnt, 1);
               check("frame_end_fs", sFs, 0);
            end
            361: check("frame2_fs", sFs, 1);
            640: check("d_blank_last", dBlankN, 1);
            641: check("d_blank_fp", dBlankN, 0);
            656: check("d_hs_before", dHs, 1);
            657: check("d_hs_fall", dHs, 0);
            752: check("d_hs_last", dHs, 0);
            753: check("d_hs_rise", dHs, 1);
            1456: check("d_hs2_before", dHs, 1);
            1457: check("d_hs2_fall", dHs, 0);
            default: ;
         endcase
      end

      // Phase B: synchronous reset while READ_Request is high, EN still 1
      found = 0;
      for (int i = 0; i < 400; i++) begin
         if (sRr) begin
            found = 1;
            break;
         end
         tick();
      end
      check("rr_seen", found, 1);
      RST = 1'b1;
      tick();
      check("mid_rst_rr", sRr, 0);
      check("mid_rst_hs", sHs, 1);
      check("mid_rst_vs", sVs, 1);
      check("mid_rst_blank", sBlankN, 0);
      check("mid_rst_busy", sBusy, 0);
      RST = 1'b0;
      EN  = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("post_rst_idle", sBusy, 0);
      check("post_rst_fs", sFs, 0);
      EN = 1'b1;
      tick();
      check("restart_k0_fs", sFs, 0);
      tick();
      check("restart_fs", sFs, 1);
      check("restart_busy", sBusy, 1);

      // Phase C: drop EN at v=5; frame must still complete
      rrCnt = 0; vsLowCnt = 0; busyCnt = 0;
      for (int k = 2; k <= 700; k++) begin
         tick();
         if (k == 121) EN = 1'b0;
         if (k >= 122 && k <= 360) begin
            if (sRr) rrCnt++;
            if (!sVs) vsLowCnt++;
         end
         if (k >= 361) begin
            if (sRr) rrCnt++;
            if (sBusy) busyCnt++;
         end
         if (k == 360) begin
            check("drop_last_busy", sBusy, 1);
            check("drop_tail_rr", rrCnt, 12);
            check("drop_tail_vs", vsLowCnt, 48);
         end
         if (k == 361) begin
            check("drop_idle_busy", sBusy, 0);
            check("drop_idle_fs", sFs, 0);
         end
      end
      check("drop_rr_after", rrCnt, 12);
      check("drop_busy_after", busyCnt, 0);
      check("drop_idle_hs", sHs, 1);

      EN = 1'b1;
      tick();
      check("reen_k0_fs", sFs, 0);
      tick();
      check("reen_fs", sFs, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
